// File: rtl/var_delay_line.sv
// var_delay_line: multi-channel delay line with a runtime-selectable tap.
// All channels share one clock enable and one delay select, so they stay
// mutually aligned. A saturating fill counter reports when the selected tap
// holds only data shifted in since the last reset or flush.
module var_delay_line #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned MAX_DELAYS = 16,
    parameter int unsigned DLYW       = $clog2(MAX_DELAYS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cen_i,
    input  logic                      flush_i,
    input  logic [DLYW-1:0]           dly_i,
    input  logic                      vld_i,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    output logic                      vld_o,
    output logic [CHANNELS*WIDTH-1:0] d_o,
    output logic                      primed_o
);

    localparam int unsigned DW = CHANNELS * WIDTH;
    // Each stage carries the data word with its valid bit in the MSB.
    localparam int unsigned SW = DW + 1;
    localparam logic [DLYW-1:0] MAX_DLY = DLYW'(MAX_DELAYS);

    logic [SW-1:0]   stage_q [MAX_DELAYS];
    logic [SW-1:0]   stage_d [MAX_DELAYS];
    logic [DLYW-1:0] fill_q;
    logic [DLYW-1:0] fill_d;
    logic [DLYW-1:0] dly_eff;
    logic [SW-1:0]   tap;

    // Requests beyond the physical depth behave as the deepest tap.
    assign dly_eff = (dly_i > MAX_DLY) ? MAX_DLY : dly_i;

    // Next-state of the shift stages and fill counter; flush beats enable.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        for (int k = 0; k < MAX_DELAYS; k++) begin
            stage_d[k] = stage_q[k];
        end
        fill_d = fill_q;

        if (flush_i) begin
            for (int k = 0; k < MAX_DELAYS; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (cen_i) begin
            stage_d[0] = {vld_i, d_i};
            for (int k = 1; k < MAX_DELAYS; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != MAX_DLY) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // State registers: stages and fill counter, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the stage array is reset, unlike a typical RAM, because the
        // outputs must read zero immediately while reset is held. Sequential
        // state uses non-blocking assignments so every flop samples the
        // pre-edge values of its neighbours.
        if (!rst_ni) begin
            for (int k = 0; k < MAX_DELAYS; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int k = 0; k < MAX_DELAYS; k++) begin
                stage_q[k] <= stage_d[k];
            end
            fill_q <= fill_d;
        end
    end

    // Output tap select: zero delay bypasses, otherwise read stage[dly_eff-1].
    always_comb begin
        tap = {vld_i, d_i};
        for (int k = 0; k < MAX_DELAYS; k++) begin
            if (dly_eff == DLYW'(k + 1)) begin
                tap = stage_q[k];
            end
        end
    end

    assign d_o      = tap[DW-1:0];
    assign vld_o    = tap[DW];
    assign primed_o = (fill_q >= dly_eff);

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line (WIDTH=8, CHANNELS=3, MAX_DELAYS=16).
// A table of directed vectors covers fill, flush and enable gaps; hand-written
// sequences cover bypass, clamp, delay changes and asynchronous reset.
module tb_var_delay_line;

    localparam int W    = 8;
    localparam int C    = 3;
    localparam int M    = 16;
    localparam int DLYW = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            cen_i;
    logic            flush_i;
    logic [DLYW-1:0] dly_i;
    logic            vld_i;
    logic [C*W-1:0]  d_i;
    logic            vld_o;
    logic [C*W-1:0]  d_o;
    logic            primed_o;

    int checks   = 0;
    int failures = 0;

    var_delay_line #(
        .WIDTH     (W),
        .CHANNELS  (C),
        .MAX_DELAYS(M)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .cen_i   (cen_i),
        .flush_i (flush_i),
        .dly_i   (dly_i),
        .vld_i   (vld_i),
        .d_i     (d_i),
        .vld_o   (vld_o),
        .d_o     (d_o),
        .primed_o(primed_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic           cen;
        logic           flush;
        logic           vld;
        logic [4:0]     dly;
        logic [23:0]    d;
        logic           e_vld;
        logic [23:0]    e_d;
        logic           e_p;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cen, input logic flush, input logic vld,
                                input logic [4:0] dly, input logic [23:0] d,
                                input logic e_vld, input logic [23:0] e_d, input logic e_p);
        vec_t v;
        v.cen = cen; v.flush = flush; v.vld = vld; v.dly = dly; v.d = d;
        v.e_vld = e_vld; v.e_d = e_d; v.e_p = e_p;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [23:0] ed, input logic ep);
        check({name, ".vld_o"},    {31'd0, vld_o},    {31'd0, ev});
        check({name, ".d_o"},      {8'd0, d_o},       {8'd0, ed});
        check({name, ".primed_o"}, {31'd0, primed_o}, {31'd0, ep});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Fill at delay 4: output lags input by four enabled edges.
        vecs.push_back(mk(1, 0, 1, 4, 24'h010203, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h020304, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h030405, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h040506, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h050607, 1, 24'h010203, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h060708, 1, 24'h020304, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h070809, 1, 24'h030405, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h08090A, 1, 24'h040506, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h090A0B, 1, 24'h050607, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h0A0B0C, 1, 24'h060708, 1));
        // Flush together with enable after 10 shifts; 0B0C0D must never emerge.
        vecs.push_back(mk(1, 1, 1, 4, 24'h0B0C0D, 1, 24'h070809, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'h0C0D0E, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h0D0E0F, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h0E0F10, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h0F1011, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'h101112, 1, 24'h0C0D0E, 1));
        // Flush without enable, then enable toggling 1,0,1,0.
        vecs.push_back(mk(0, 1, 1, 4, 24'h111213, 1, 24'h0D0E0F, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0001, 0, 24'h000000, 0));
        vecs.push_back(mk(0, 0, 0, 4, 24'hFFFFFF, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0002, 0, 24'h000000, 0));
        vecs.push_back(mk(0, 0, 0, 4, 24'hFFFFFF, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0003, 0, 24'h000000, 0));
        vecs.push_back(mk(0, 0, 0, 4, 24'hFFFFFF, 0, 24'h000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0004, 0, 24'h000000, 0));
        vecs.push_back(mk(0, 0, 0, 4, 24'hFFFFFF, 1, 24'hAA0001, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0005, 1, 24'hAA0001, 1));
        vecs.push_back(mk(0, 0, 0, 4, 24'hFFFFFF, 1, 24'hAA0002, 1));
        vecs.push_back(mk(1, 0, 1, 4, 24'hAA0006, 1, 24'hAA0002, 1));

        // Reset state, bypass and tap-1 while reset is held.
        rst_ni = 1'b0; cen_i = 1'b0; flush_i = 1'b0;
        dly_i = 5'd0; vld_i = 1'b1; d_i = 24'h123456;
        #2;
        check_out("rst_bypass", 1'b1, 24'h123456, 1'b1);
        dly_i = 5'd1;
        #1;
        check_out("rst_tap1", 1'b0, 24'h000000, 1'b0);
        dly_i = 5'd4; d_i = '0; vld_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cen_i = vecs[i].cen; flush_i = vecs[i].flush; vld_i = vecs[i].vld;
            dly_i = vecs[i].dly; d_i = vecs[i].d;
            #3;
            check_out($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_d, vecs[i].e_p);
            step();
        end

        // Clamp: dly_i=31 acts as 16, fill counter saturates without wrapping.
        cen_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0; dly_i = 5'd31; vld_i = 1'b1;
        for (int s = 0; s < 34; s++) begin
            d_i = 24'hC00000 + 24'(s);
            #3;
            check_out($sformatf("clamp%0d", s), (s >= 16),
                      (s >= 16) ? 24'hC00000 + 24'(s - 16) : 24'h0, (s >= 16));
            if (s == 15 || s == 16) begin
                dly_i = 5'd16;
                #1;
                check_out($sformatf("dly16_%0d", s), (s >= 16),
                          (s >= 16) ? 24'hC00000 + 24'(s - 16) : 24'h0, (s >= 16));
                dly_i = 5'd31;
            end
            step();
        end

        // Delay change: primed at 4 with six shifts, move to 8, then to 2.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; dly_i = 5'd4;
        for (int n = 1; n <= 6; n++) begin
            d_i = 24'hB00000 + 24'(n);
            step();
        end
        check_out("chg_at4", 1'b1, 24'hB00003, 1'b1);
        dly_i = 5'd8;
        #1;
        check_out("chg_to8", 1'b0, 24'h000000, 1'b0);
        d_i = 24'hB00007;
        step();
        check("chg_8_fill7.primed_o", {31'd0, primed_o}, 32'd0);
        d_i = 24'hB00008;
        step();
        check_out("chg_8_fill8", 1'b1, 24'hB00001, 1'b1);
        dly_i = 5'd2;
        #1;
        check_out("chg_to2", 1'b1, 24'hB00007, 1'b1);

        // Asynchronous reset between edges clears outputs before the next edge.
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 24'h000000, 1'b0);
        cen_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        cen_i = 1'b1; d_i = 24'hD00001;
        #3;
        check_out("refill0", 1'b0, 24'h000000, 1'b0);
        step();
        d_i = 24'hD00002;
        check_out("refill1", 1'b0, 24'h000000, 1'b0);
        step();
        check_out("refill2", 1'b1, 24'hD00001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_delay_line.md
# var_delay_line

Multi-channel, runtime-selectable delay line with valid tracking, flush and fill status. It is the parametrised successor to the fixed-depth shift register. Use it in the video pipeline to align pixel data and sync/valid side-bands across paths whose latency is set at run time, up to a compile-time maximum. All channels share one clock enable and one delay setting, so they stay mutually aligned.

## Interface
- `WIDTH`, default 8: bits per channel.
- `CHANNELS`, default 3: number of parallel channels, packed channel 0 in LSBs.
- `MAX_DELAYS`, default 16: maximum delay in enabled cycles; must be ≥ 1.
- `DLYW`, default `$clog2(MAX_DELAYS+1)`: width of the delay select.

- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `cen_i` input 1: clock enable; the line shifts only when high.
- `flush_i` input 1: synchronous clear of line contents and fill state.
- `dly_i` input DLYW: requested delay, 0..MAX_DELAYS; larger values clamp to MAX_DELAYS.
- `vld_i` input 1: valid flag accompanying `d_i`.
- `d_i` input CHANNELS*WIDTH: packed input data.
- `vld_o` output 1: delayed valid.
- `d_o` output CHANNELS*WIDTH: delayed data.
- `primed_o` output 1: high when the selected tap holds data shifted in since the last reset or flush.

## Operation
- Storage is MAX_DELAYS stages, each holding CHANNELS*WIDTH data bits plus 1 valid bit.
- Effective delay: `dly_eff = min(dly_i, MAX_DELAYS)`.
- Shift, on a rising edge with `cen_i`=1 and `flush_i`=0:
  - stage[0] takes {`vld_i`, `d_i`};
  - stage[k] takes stage[k-1] for k ≥ 1.
- Hold: with `cen_i`=0, all stages and the fill counter are unchanged.
- Output tap, combinational from `dly_i`:
  - `dly_eff` = 0: `d_o`=`d_i` and `vld_o`=`vld_i` (pure bypass);
  - otherwise `d_o`/`vld_o` come from stage[`dly_eff`-1].
- Fill counter `fill_cnt`, width DLYW:
  - increments on each shift;
  - saturates at MAX_DELAYS;
  - cleared by reset or flush.
- `primed_o` = (`fill_cnt` ≥ `dly_eff`), combinational.
- Flush (`flush_i`=1 at an edge):
  - all data bits, valid bits and `fill_cnt` go to 0;
  - flush has priority over `cen_i`, so `d_i` is not captured that cycle.
- Delay change: a new `dly_i` selects its tap in the same cycle; there is no reload or drain.
  - Increasing the delay drops `primed_o` until `fill_cnt` catches up.
  - Decreasing the delay never deasserts `primed_o`.
- The block has no handshake and no back-pressure; `cen_i` is the only flow control.

## Timing
- Reset (`rst_ni`=0, asynchronous): all stages and `fill_cnt` are 0 immediately, so:
  - `vld_o`=0 and `d_o`=0 when `dly_eff` ≥ 1;
  - `primed_o`=0 when `dly_eff` ≥ 1 and 1 when `dly_eff`=0;
  - with `dly_eff`=0, `d_o`/`vld_o` follow `d_i`/`vld_i` even in reset.
- Reset release takes effect on the first clock edge after `rst_ni` rises. Reset during operation discards all contents; there is no partial state.
- Latency: exactly `dly_eff` `cen_i`-qualified edges. Disabled cycles stretch wall-clock latency without reordering data.
- `primed_o` rises combinationally after the `dly_eff`-th shift following reset or flush, in the same cycle that the first post-flush sample appears at `d_o`.
- At saturation, `fill_cnt`=MAX_DELAYS stays there; further shifts do not wrap.
- Flush and `cen_i` together: flush result only. The stage contents afterwards are all zero.
- `dly_i` above MAX_DELAYS behaves exactly as MAX_DELAYS, including for `primed_o`.

## Test plan
- Reset then fill: WIDTH=8, CHANNELS=3, MAX_DELAYS=16, `dly_i`=4, `cen_i`=1, drive `d_i`=0x010203, then +0x010101 each cycle, with `vld_i`=1.
  - Required: `d_o`=0 and `primed_o`=0 for 3 edges;
  - after the 4th edge `d_o`=0x010203, `vld_o`=1, `primed_o`=1;
  - sequence then tracks input with a 4-cycle lag.
- Clock enable gaps: as above, with `cen_i` toggling 1,0,1,0.
  - Required: output appears after 4 enabled edges (8 clocks) with no sample lost or duplicated.
- Bypass and clamp:
  - `dly_i`=0 gives `d_o`=`d_i` in the same cycle and `primed_o`=1 during reset;
  - `dly_i`=31 gives behaviour identical to 16, with `primed_o` rising after the 16th shift.
- Flush mid-stream: after 10 shifts at `dly_i`=4, assert `flush_i` together with `cen_i`.
  - Required: next cycle `d_o`=0, `vld_o`=0, `primed_o`=0;
  - `primed_o` returns after 4 more shifts, and the flush-cycle `d_i` never appears at the output.
- Delay change: primed at `dly_i`=4 with `fill_cnt`=6, switch to 8.
  - Required: `d_o` immediately shows the stage[7] contents and `primed_o`=0;
  - `primed_o`=1 after 2 more shifts;
  - switching 8→2 keeps `primed_o`=1.
- Async reset mid-operation: pull `rst_ni` low between clock edges.
  - Required: `vld_o`=0 and `d_o`=0 before the next edge (`dly_eff` ≥ 1);
  - full refill is required before `primed_o` returns.
